// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Brief    : Instruction-fetch stage with PC, imem request handshake and the
//            IF/ID pipeline register. Buffers a returned instruction while a
//            stall or flush blocks the IF/ID write; handles EX redirects,
//            including ones that arrive while a request is still outstanding.
// Revision : 1.0  initial release
// ============================================================================
module fetch_stage #(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    INST_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
   parameter logic [INST_WIDTH-1:0] NOP_INST   = 32'h0000_0013
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  pc_write,
   input  logic                  IF_ID_write,
   input  logic                  IF_ID_flush,
   input  logic                  branch_taken,
   input  logic [ADDR_WIDTH-1:0] branch_target,
   output logic                  imem_req,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   input  logic                  imem_ready,
   input  logic [INST_WIDTH-1:0] imem_rdata,
   output logic [ADDR_WIDTH-1:0] IF_ID_pc,
   output logic [INST_WIDTH-1:0] IF_ID_inst,
   output logic                  IF_ID_valid
);

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2
   } state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic                  kill_q, kill_d;
   logic [ADDR_WIDTH-1:0] kill_addr_q, kill_addr_d;   // address of the orphaned request
   logic [INST_WIDTH-1:0] hold_inst_q, hold_inst_d;
   logic [ADDR_WIDTH-1:0] if_pc_q, if_pc_d;
   logic [INST_WIDTH-1:0] if_inst_q, if_inst_d;
   logic                  if_valid_q, if_valid_d;

   logic                  stall;
   logic                  blocked;   // IF/ID may not accept a new instruction this cycle
   logic [ADDR_WIDTH-1:0] target_aligned;
   logic [ADDR_WIDTH-1:0] pc_plus4;

   assign stall          = !pc_write || !IF_ID_write;
   assign blocked        = stall || IF_ID_flush;
   assign target_aligned = {branch_target[ADDR_WIDTH-1:2], 2'b00};
   assign pc_plus4       = pc_q + ADDR_WIDTH'(4);

   // Request outputs come from registered state only; a killed request keeps
   // presenting its original address until memory answers it.
   assign imem_req    = (state_q == FETCH);
   assign imem_addr   = kill_q ? kill_addr_q : pc_q;
   assign IF_ID_pc    = if_pc_q;
   assign IF_ID_inst  = if_inst_q;
   assign IF_ID_valid = if_valid_q;

   // Next-state: redirect beats flush beats stall beats normal advance.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      kill_d      = kill_q;
      kill_addr_d = kill_addr_q;
      hold_inst_d = hold_inst_q;
      if_pc_d     = if_pc_q;
      if_inst_d   = if_inst_q;
      if_valid_d  = if_valid_q;

      // Both a redirect and a flush leave a bubble with the old IF/ID pc.
      if (branch_taken || IF_ID_flush) begin
         if_inst_d  = NOP_INST;
         if_valid_d = 1'b0;
      end

      if (branch_taken) begin
         pc_d = target_aligned;
         case (state_q)
            FETCH: begin
               if (kill_q) begin
                  if (imem_ready) kill_d = 1'b0;   // orphan answered, discard it
               end else if (!imem_ready) begin
                  kill_d      = 1'b1;
                  kill_addr_d = pc_q;
               end
            end
            default: state_d = FETCH;             // BOOT, HOLD (held inst dropped)
         endcase
      end else begin
         case (state_q)
            BOOT: state_d = FETCH;
            FETCH: begin
               if (imem_ready) begin
                  if (kill_q) begin
                     kill_d = 1'b0;
                  end else if (blocked) begin
                     hold_inst_d = imem_rdata;
                     state_d     = HOLD;
                  end else begin
                     if_pc_d    = pc_q;
                     if_inst_d  = imem_rdata;
                     if_valid_d = 1'b1;
                     pc_d       = pc_plus4;
                  end
               end
            end
            HOLD: begin
               if (!blocked) begin
                  if_pc_d    = pc_q;
                  if_inst_d  = hold_inst_q;
                  if_valid_d = 1'b1;
                  pc_d       = pc_plus4;
                  state_d    = FETCH;
               end
            end
            default: state_d = BOOT;
         endcase
      end
   end

   // State and pipeline registers; reset abandons any transaction at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= BOOT;
         pc_q        <= RESET_PC;
         kill_q      <= 1'b0;
         kill_addr_q <= '0;
         hold_inst_q <= '0;
         if_pc_q     <= '0;
         if_inst_q   <= NOP_INST;
         if_valid_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         kill_q      <= kill_d;
         kill_addr_q <= kill_addr_d;
         hold_inst_q <= hold_inst_d;
         if_pc_q     <= if_pc_d;
         if_inst_q   <= if_inst_d;
         if_valid_q  <= if_valid_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Brief    : Self-checking bench for fetch_stage. Each stimulus row pushes the
//            expected post-edge outputs into a scoreboard queue; the entry is
//            popped and compared after the edge. A second instance checks PC
//            wrap-around from RESET_PC = 0xFFFF_FFFC.
// Revision : 1.0  initial release
// ============================================================================
module tb_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        pc_write, IF_ID_write, IF_ID_flush, branch_taken, imem_ready;
   logic [31:0] branch_target;
   logic        imem_req, w_req;
   logic [31:0] imem_addr, imem_rdata, IF_ID_pc, IF_ID_inst;
   logic [31:0] w_addr, w_rdata, w_pc, w_inst;
   logic        IF_ID_valid, w_valid;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   // Instruction memory content: a simple address scramble, never equal to NOP.
   function automatic logic [31:0] mem(input logic [31:0] a);
      return a ^ 32'h1357_9BDF;
   endfunction

   assign imem_rdata = mem(imem_addr);
   assign w_rdata    = mem(w_addr);

   fetch_stage #(.ADDR_WIDTH(32), .INST_WIDTH(32), .RESET_PC(32'h0000_0000), .NOP_INST(NOP)) dut (
      .clk(clk), .rst_n(rst_n), .pc_write(pc_write), .IF_ID_write(IF_ID_write),
      .IF_ID_flush(IF_ID_flush), .branch_taken(branch_taken), .branch_target(branch_target),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
      .IF_ID_pc(IF_ID_pc), .IF_ID_inst(IF_ID_inst), .IF_ID_valid(IF_ID_valid)
   );

   fetch_stage #(.ADDR_WIDTH(32), .INST_WIDTH(32), .RESET_PC(32'hFFFF_FFFC), .NOP_INST(NOP)) u_wrap (
      .clk(clk), .rst_n(rst_n), .pc_write(pc_write), .IF_ID_write(IF_ID_write),
      .IF_ID_flush(IF_ID_flush), .branch_taken(branch_taken), .branch_target(branch_target),
      .imem_req(w_req), .imem_addr(w_addr), .imem_ready(imem_ready), .imem_rdata(w_rdata),
      .IF_ID_pc(w_pc), .IF_ID_inst(w_inst), .IF_ID_valid(w_valid)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   typedef struct {
      logic        rdy, pcw, ifw, fl, br;
      logic [31:0] tgt;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_v;
      logic [31:0] e_pc;
   } row_t;

   typedef struct {
      logic        req;
      logic [31:0] addr;
      logic        v;
      logic [31:0] pc;
      logic [31:0] inst;
   } exp_t;

   row_t rows[$];
   exp_t exp_q[$];

   task automatic add(input logic rdy, pcw, ifw, fl, br, input logic [31:0] tgt,
                      input logic e_req, input logic [31:0] e_addr,
                      input logic e_v, input logic [31:0] e_pc);
      row_t r;
      r.rdy = rdy; r.pcw = pcw; r.ifw = ifw; r.fl = fl; r.br = br; r.tgt = tgt;
      r.e_req = e_req; r.e_addr = e_addr; r.e_v = e_v; r.e_pc = e_pc;
      rows.push_back(r);
   endtask

   initial begin
      exp_t e;
      //   rdy pcw ifw fl br tgt          req addr       v  IF_ID_pc
      add(1, 1, 1, 0, 0, 32'h0,    1, 32'h000, 0, 32'h000); // E0: BOOT->FETCH
      add(1, 1, 1, 0, 0, 32'h0,    1, 32'h004, 1, 32'h000); // E1: first inst
      add(1, 1, 1, 0, 0, 32'h0,    1, 32'h008, 1, 32'h004);
      add(1, 0, 0, 0, 0, 32'h0,    0, 32'h008, 1, 32'h004); // load-use stall -> HOLD
      add(1, 1, 1, 0, 0, 32'h0,    1, 32'h00C, 1, 32'h008); // held inst released
      add(1, 1, 1, 0, 0, 32'h0,    1, 32'h010, 1, 32'h00C);
      add(0, 1, 1, 0, 0, 32'h0,    1, 32'h010, 1, 32'h00C); // memory wait x3
      add(0, 1, 1, 0, 0, 32'h0,    1, 32'h010, 1, 32'h00C);
      add(0, 1, 1, 0, 0, 32'h0,    1, 32'h010, 1, 32'h00C);
      add(1, 1, 1, 0, 0, 32'h0,    1, 32'h014, 1, 32'h010);
      add(1, 1, 1, 0, 0, 32'h0,    1, 32'h018, 1, 32'h014);
      add(1, 1, 1, 0, 0, 32'h0,    1, 32'h01C, 1, 32'h018);
      add(1, 1, 1, 0, 0, 32'h0,    1, 32'h020, 1, 32'h01C);
      add(0, 1, 1, 0, 1, 32'h103,  1, 32'h020, 0, 32'h01C); // redirect, 0x20 pending
      add(0, 1, 1, 0, 0, 32'h0,    1, 32'h020, 0, 32'h01C);
      add(1, 1, 1, 0, 0, 32'h0,    1, 32'h100, 0, 32'h01C); // killed data dropped
      add(1, 1, 1, 0, 0, 32'h0,    1, 32'h104, 1, 32'h100);
      add(1, 1, 1, 0, 0, 32'h0,    1, 32'h108, 1, 32'h104);
      add(1, 1, 0, 0, 0, 32'h0,    0, 32'h108, 1, 32'h104); // stall -> HOLD
      add(1, 0, 1, 1, 1, 32'h200,  1, 32'h200, 0, 32'h104); // branch+flush in HOLD
      add(1, 1, 1, 0, 0, 32'h0,    1, 32'h204, 1, 32'h200);
      add(1, 1, 1, 1, 0, 32'h0,    0, 32'h204, 0, 32'h200); // flush alone -> HOLD
      add(1, 1, 1, 0, 0, 32'h0,    1, 32'h208, 1, 32'h204);
      add(1, 1, 1, 0, 1, 32'h301,  1, 32'h300, 0, 32'h204); // redirect with ready
      add(1, 1, 1, 0, 0, 32'h0,    1, 32'h304, 1, 32'h300);
      add(0, 1, 1, 0, 1, 32'h400,  1, 32'h304, 0, 32'h300); // redirect, pending
      add(0, 1, 1, 0, 1, 32'h500,  1, 32'h304, 0, 32'h300); // second redirect
      add(1, 1, 1, 0, 0, 32'h0,    1, 32'h500, 0, 32'h300);
      add(1, 1, 1, 0, 0, 32'h0,    1, 32'h504, 1, 32'h500);

      rst_n = 1'b0; pc_write = 1'b1; IF_ID_write = 1'b1; IF_ID_flush = 1'b0;
      branch_taken = 1'b0; branch_target = '0; imem_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_req",   32'(imem_req),    32'h0);
      check("rst_addr",  imem_addr,        32'h0);
      check("rst_valid", 32'(IF_ID_valid), 32'h0);
      check("rst_pc",    IF_ID_pc,         32'h0);
      check("rst_inst",  IF_ID_inst,       NOP);
      check("rst_waddr", w_addr,           32'hFFFF_FFFC);
      rst_n = 1'b1;

      foreach (rows[i]) begin
         imem_ready    = rows[i].rdy;
         pc_write      = rows[i].pcw;
         IF_ID_write   = rows[i].ifw;
         IF_ID_flush   = rows[i].fl;
         branch_taken  = rows[i].br;
         branch_target = rows[i].tgt;
         e.req  = rows[i].e_req;
         e.addr = rows[i].e_addr;
         e.v    = rows[i].e_v;
         e.pc   = rows[i].e_pc;
         e.inst = rows[i].e_v ? mem(rows[i].e_pc) : NOP;
         exp_q.push_back(e);
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         check($sformatf("r%0d_req", i),   32'(imem_req),    32'(e.req));
         check($sformatf("r%0d_addr", i),  imem_addr,        e.addr);
         check($sformatf("r%0d_valid", i), 32'(IF_ID_valid), 32'(e.v));
         check($sformatf("r%0d_pc", i),    IF_ID_pc,         e.pc);
         check($sformatf("r%0d_inst", i),  IF_ID_inst,       e.inst);
         if (i == 0) begin
            check("wrap_addr0",  w_addr,        32'hFFFF_FFFC);
            check("wrap_valid0", 32'(w_valid),  32'h0);
         end
         if (i == 1) begin
            check("wrap_addr1", w_addr,         32'h0000_0000);
            check("wrap_pc1",   w_pc,           32'hFFFF_FFFC);
            check("wrap_inst1", w_inst,         mem(32'hFFFF_FFFC));
         end
         @(negedge clk);
      end

      // Asynchronous reset in the middle of an active request.
      imem_ready = 1'b0; pc_write = 1'b1; IF_ID_write = 1'b1;
      IF_ID_flush = 1'b0; branch_taken = 1'b0;
      check("pre_areset_req", 32'(imem_req), 32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      check("areset_req",   32'(imem_req),    32'h0);
      check("areset_addr",  imem_addr,        32'h0);
      check("areset_valid", 32'(IF_ID_valid), 32'h0);
      check("areset_inst",  IF_ID_inst,       NOP);
      check("areset_pc",    IF_ID_pc,         32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
